bild_puffer: RTL and testbench
==============================

# bild_puffer

Single-clock frame buffer of 8-bit pixels, written by the CPU through a memory-mapped store and read continuously by the HDMI scan-out. It sits between the CPU data bus and the HDMI pixel fetch. The write port takes an (x, y, color) triple. The read port returns the stored color for the HDMI raster position one cycle later. After reset the block clears itself to black by sweeping the whole buffer.

## Interface
- WIDTH, default 160: pixels per line. Valid x range is 0..WIDTH-1, and WIDTH must be 256 or less.
- HEIGHT, default 120: lines. Valid y range is 0..HEIGHT-1, and HEIGHT must be 256 or less.
- clk  in  1  single clock. All state changes on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- x  in  8  write column.
- y  in  8  write row.
- color  in  8  write pixel value.
- write  in  1  write strobe, sampled on the rising edge of clk.
- x_data  in  8  read column, driven by the HDMI block.
- y_data  in  8  read row, driven by the HDMI block.
- pixelData  out  8  registered read data.
- clearing  out  1  high while the post-reset clear sweep runs.

## Operation
- **Storage:** WIDTH*HEIGHT words of 8 bits. Linear address = y*WIDTH + x. Address width is ceil(log2(WIDTH*HEIGHT)). The multiply uses unsigned arithmetic.
- **States:**
  - CLEAR: entered while Reset is low and stays active after release.
  - RUN: normal operation.
- **Reset asserted (Reset=0), asynchronous:**
  - State goes to CLEAR.
  - Clear counter goes to 0.
  - pixelData goes to 0.
  - clearing goes to 1.
  - Memory contents are not reset directly.
- **CLEAR:**
  - Each cycle writes 0 at the counter address, then increments the counter.
  - After address WIDTH*HEIGHT-1 is written, the next edge enters RUN and clearing drops to 0.
  - Duration is exactly WIDTH*HEIGHT cycles after Reset rises.
  - The write port is ignored.
  - pixelData is forced to 0.
- **RUN, write:** when write=1, x<WIDTH and y<HEIGHT, mem[y*WIDTH+x] <= color on the edge. Writes with an out-of-range x or y are dropped without wrapping. For example, x=WIDTH must not alias to the next line.
- **RUN, read:** every edge, pixelData <= mem[y_data*WIDTH+x_data] if x_data<WIDTH and y_data<HEIGHT. Otherwise pixelData <= 0, which gives a black border outside the picture.
- **Same address written and read on one edge:** read-before-write. pixelData gets the old value, and the new value is visible from the next edge.
- **Ports:** write and read are independent, so one write and one read per cycle.
- **Reset mid-write or mid-sweep:** the in-flight write is discarded and the sweep restarts from 0.

## Timing
- Read latency is 1 cycle: (x_data, y_data) presented before edge N gives pixelData valid after edge N.
- Write latency is 1 cycle: data written on edge N is readable via the address presented before edge N+1, with pixelData valid after edge N+1.
- There is no handshake. write is a level sampled each edge, so holding it high for k cycles performs k identical writes.
- Reset assertion affects pixelData and clearing immediately, without waiting for clk. Release is taken synchronously at the next edge.

## Test plan
- **Reset then sweep:** pulse Reset low, release, and count edges.
  - clearing stays 1 for exactly 19200 cycles (160*120).
  - pixelData=0 throughout the sweep.
  - A read of (5,5) after the sweep returns 0.
- **Basic write/read:** write color 8'hA5 at (10,20), then read (10,20).
  - pixelData=8'hA5 one cycle after the address is presented.
  - (11,20) still reads 0.
- **Corners:** write 8'h01 at (0,0) and 8'hFF at (159,119), then read both.
  - The reads return 01 and FF.
  - A write at (160,0) is dropped: (0,1) still reads 0.
- **Out-of-range read:** after writing 8'h33 at (0,0), read (200,0), then (0,130).
  - pixelData=0 for both.
  - Reading (0,0) returns 33.
- **Read/write collision:** with (3,3)=8'h11 stored, write 8'h22 at (3,3) on the same edge that reads (3,3).
  - pixelData=11 that cycle.
  - pixelData=22 on the following read.
- **Reset mid-operation:** assert Reset during a write burst and halfway through a sweep.
  - pixelData=0 and clearing=1 immediately, without a clock edge.
  - The sweep restarts and again lasts 19200 cycles.
  - Written pixels read 0 afterwards.

Source files
------------

// File: rtl/bild_puffer.sv
`timescale 1ns/1ps
// bild_puffer: single-clock 8-bit frame buffer between the CPU store path and
// the HDMI pixel fetch. After reset it sweeps the whole buffer to black.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   Reset      asynchronous active-low reset
//   x, y       CPU write column / row
//   color      CPU write pixel value
//   write      CPU write strobe (level, one write per edge while high)
//   x_data     HDMI read column
//   y_data     HDMI read row
//   pixelData  registered read data, one cycle after the read address
//   clearing   high while the post-reset clear sweep runs
module bild_puffer #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic [7:0] color,
  input  logic       write,
  input  logic [7:0] x_data,
  input  logic [7:0] y_data,
  output logic [7:0] pixelData,
  output logic       clearing
);

  localparam int DEPTH = WIDTH * HEIGHT;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] RUN   = 1'b1;

  logic [0:0]    state;
  logic [AW-1:0] clr_cnt;
  logic [7:0]    mem [DEPTH];

  logic          wr_ok;
  logic          rd_ok;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;

  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_din;

  // 9-bit compares so a dimension of exactly 256 still works.
  assign wr_ok = (9'(x) < 9'(WIDTH)) && (9'(y) < 9'(HEIGHT));
  assign rd_ok = (9'(x_data) < 9'(WIDTH)) && (9'(y_data) < 9'(HEIGHT));

  // Address math is done modulo 2^AW; for in-range coordinates the true
  // linear address is below DEPTH, so the truncated result is exact.
  assign wr_addr = AW'(y) * AW'(WIDTH) + AW'(x);
  assign rd_addr = AW'(y_data) * AW'(WIDTH) + AW'(x_data);

  assign clearing = (state == CLEAR);

  // Control: clear sweep counter and CLEAR/RUN state.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else if (state == CLEAR) begin
      if (clr_cnt == AW'(DEPTH - 1)) begin
        state   <= RUN;
        clr_cnt <= '0;
      end else begin
        clr_cnt <= clr_cnt + AW'(1);
      end
    end
  end

  // Single write port shared by the sweep and the CPU. The CPU port is shut
  // out for the whole of CLEAR, which also discards a write in flight when
  // Reset hits. While Reset is held the sweep keeps zeroing address 0; the
  // sweep clears it anyway, so this is not observable.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = wr_addr;
    mem_din  = color;
    if (state == CLEAR) begin
      mem_we   = 1'b1;
      mem_addr = clr_cnt;
      mem_din  = '0;
    end else begin
      mem_we   = write && wr_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_din;
    end
  end

  // Read stage: old memory contents are sampled on the same edge as a write,
  // giving read-before-write on an address collision. Outside the picture
  // the output is black.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      pixelData <= '0;
    end else if (state == CLEAR || !rd_ok) begin
      pixelData <= '0;
    end else begin
      pixelData <= mem[rd_addr];
    end
  end

endmodule

// File: tb/tb_bild_puffer.sv
`timescale 1ns/1ps
// Self-checking bench for bild_puffer: a frame-level reference model plus
// directed vectors with hand-computed expectations.
module tb_bild_puffer;

  localparam int W     = 160;
  localparam int H     = 120;
  localparam int DEPTH = W * H;

  logic       clk = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] x = '0;
  logic [7:0] y = '0;
  logic [7:0] color = '0;
  logic       write = 1'b0;
  logic [7:0] x_data = '0;
  logic [7:0] y_data = '0;
  logic [7:0] pixelData;
  logic       clearing;

  int vectors = 0;
  int miscompares = 0;
  logic chk_en = 1'b0;

  bild_puffer #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk       (clk),
    .Reset     (Reset),
    .x         (x),
    .y         (y),
    .color     (color),
    .write     (write),
    .x_data    (x_data),
    .y_data    (y_data),
    .pixelData (pixelData),
    .clearing  (clearing)
  );

  always #5 clk = ~clk;

  // Reference model: the frame as an array, the sweep as a remaining-cycle
  // count. Any reset blanks the whole frame from the outside's point of view.
  logic [7:0] model_mem [DEPTH];
  int         sweep_left = DEPTH;
  logic [7:0] exp_pix = '0;
  logic       exp_clr = 1'b1;

  always @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      exp_pix    = '0;
      exp_clr    = 1'b1;
      sweep_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    end else if (sweep_left > 0) begin
      sweep_left = sweep_left - 1;
      exp_pix    = '0;
      exp_clr    = (sweep_left > 0);
    end else begin
      if (int'(x_data) < W && int'(y_data) < H)
        exp_pix = model_mem[int'(y_data) * W + int'(x_data)];
      else
        exp_pix = '0;
      if (write && int'(x) < W && int'(y) < H)
        model_mem[int'(y) * W + int'(x)] = color;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      vectors++;
      if (pixelData !== exp_pix) begin
        miscompares++;
        $display("FAIL model_pix t=%0t got %h want %h", $time, pixelData, exp_pix);
      end
      vectors++;
      if (clearing !== exp_clr) begin
        miscompares++;
        $display("FAIL model_clr t=%0t got %b want %b", $time, clearing, exp_clr);
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog t=%0t got no finish want finish", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check_lit(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input int cx, input int cy, input logic [7:0] c);
    write = 1'b1;
    x     = 8'(cx);
    y     = 8'(cy);
    color = c;
    step();
    write = 1'b0;
  endtask

  task automatic rd(input int cx, input int cy, input logic [7:0] want, input string name);
    x_data = 8'(cx);
    y_data = 8'(cy);
    step();
    check_lit(name, {24'b0, pixelData}, {24'b0, want});
  endtask

  task automatic measure_sweep(input string name);
    int n = 0;
    for (int i = 0; i < 25000; i++) begin
      step();
      n++;
      if (clearing == 1'b0) break;
    end
    check_lit(name, n, 32'd19200);
  endtask

  initial begin
    #3 Reset = 1'b0;
    #1;
    check_lit("rst_pix", {24'b0, pixelData}, 32'h0);
    check_lit("rst_clr", {31'b0, clearing}, 32'h1);
    chk_en = 1'b1;
    x_data = 8'd5;
    y_data = 8'd5;
    step();
    step();
    Reset = 1'b1;
    measure_sweep("sweep1_len");
    check_lit("sweep1_done", {31'b0, clearing}, 32'h0);
    rd(5, 5, 8'h00, "rd_5_5");

    wr(10, 20, 8'hA5);
    rd(10, 20, 8'hA5, "rd_10_20");
    rd(11, 20, 8'h00, "rd_11_20");

    wr(0, 0, 8'h01);
    wr(159, 119, 8'hFF);
    rd(0, 0, 8'h01, "rd_0_0");
    rd(159, 119, 8'hFF, "rd_159_119");
    wr(160, 0, 8'h77);
    rd(0, 1, 8'h00, "rd_0_1_noalias");

    wr(0, 0, 8'h33);
    rd(200, 0, 8'h00, "rd_200_0");
    rd(0, 130, 8'h00, "rd_0_130");
    rd(0, 0, 8'h33, "rd_0_0_33");

    wr(3, 3, 8'h11);
    write  = 1'b1;
    x      = 8'd3;
    y      = 8'd3;
    color  = 8'h22;
    x_data = 8'd3;
    y_data = 8'd3;
    step();
    write  = 1'b0;
    check_lit("collide_old", {24'b0, pixelData}, 32'h11);
    step();
    check_lit("collide_new", {24'b0, pixelData}, 32'h22);

    // Reset during a write burst while the read points at a stored pixel.
    x_data = 8'd159;
    y_data = 8'd119;
    step();
    check_lit("pre_rst_pix", {24'b0, pixelData}, 32'hFF);
    for (int i = 0; i < 6; i++) wr(i, 7, 8'(8'h40 + i));
    write = 1'b1;
    x     = 8'd6;
    y     = 8'd7;
    color = 8'h46;
    Reset = 1'b0;
    #1;
    check_lit("burst_rst_pix", {24'b0, pixelData}, 32'h0);
    check_lit("burst_rst_clr", {31'b0, clearing}, 32'h1);
    step();
    Reset = 1'b1;
    write = 1'b0;

    // Reset again halfway through the sweep.
    for (int i = 0; i < 9600; i++) step();
    check_lit("half_clr", {31'b0, clearing}, 32'h1);
    Reset = 1'b0;
    #1;
    check_lit("half_rst_pix", {24'b0, pixelData}, 32'h0);
    check_lit("half_rst_clr", {31'b0, clearing}, 32'h1);
    step();
    Reset = 1'b1;
    measure_sweep("sweep3_len");

    rd(0, 7, 8'h00, "post_0_7");
    rd(5, 7, 8'h00, "post_5_7");
    rd(6, 7, 8'h00, "post_6_7");
    rd(159, 119, 8'h00, "post_159_119");
    rd(10, 20, 8'h00, "post_10_20");
    wr(6, 7, 8'h5A);
    rd(6, 7, 8'h5A, "post_wr_6_7");

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
